// File: rtl/vx_mem_tag_remap_pkg.sv
// Shared cache typing: remapped memory-tag widths for the tag-compression stage.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef CACHE_REMAP_TAG_WIDTH
`define CACHE_REMAP_TAG_WIDTH(entries) `CLOG2(entries)
`endif

package vx_mem_tag_remap_pkg;

   // Outstanding-tag depth of the remap stage in front of each cache level's memory port.
   localparam int L2_MEM_REMAP_ENTRIES = 16;
   localparam int L3_MEM_REMAP_ENTRIES = 32;

   // Downstream tag widths now depend only on the remap depth, not on upstream tag width.
   localparam int L2_MEM_REMAP_TAG_WIDTH = `CACHE_REMAP_TAG_WIDTH(L2_MEM_REMAP_ENTRIES);
   localparam int L3_MEM_REMAP_TAG_WIDTH = `CACHE_REMAP_TAG_WIDTH(L3_MEM_REMAP_ENTRIES);

   // Index width needed to name every entry of a remap table.
   function automatic int remap_tag_width(input int entries);
      return $clog2(entries);
   endfunction

endpackage

// File: rtl/vx_tag_table.sv
// One channel's tag table: allocates the lowest free index per request, restores the wide tag per response.
// Latency: 0 cycles both directions; allocation/free take effect at the next clock edge.
// Backpressure: allocating requests stall when every entry is busy; responses to free entries are sunk.
module vx_tag_table
   import vx_mem_tag_remap_pkg::*;
#(
   parameter  int NUM_ENTRIES   = 8,
   parameter  int TAG_IN_WIDTH  = 16,
   parameter  int WRITE_NO_RSP  = 1,
   localparam int TAG_OUT_WIDTH = remap_tag_width(NUM_ENTRIES),
   localparam int PEND_WIDTH    = TAG_OUT_WIDTH + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic                     req_rw,
   input  logic [TAG_IN_WIDTH-1:0]  req_tag,
   output logic                     req_ready,
   output logic                     mem_valid,
   output logic [TAG_OUT_WIDTH-1:0] mem_tag,
   input  logic                     mem_ready,
   input  logic                     rsp_valid,
   input  logic [TAG_OUT_WIDTH-1:0] rsp_idx,
   output logic                     rsp_ready,
   output logic                     core_valid,
   output logic [TAG_IN_WIDTH-1:0]  core_tag,
   input  logic                     core_ready,
   output logic [PEND_WIDTH-1:0]    pending,
   output logic                     tag_err
);

   logic [NUM_ENTRIES-1:0]   busy;
   logic [TAG_IN_WIDTH-1:0]  tag_mem [NUM_ENTRIES];
   logic [TAG_OUT_WIDTH-1:0] free_idx;
   logic [NUM_ENTRIES-1:0]   alloc_mask;
   logic [NUM_ENTRIES-1:0]   free_mask;
   logic full, alloc_needed, grant, alloc_fire, rsp_hit, free_fire;

   // Priority encoder: lowest-index free entry (0 when the table is full).
   always_comb begin
      free_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = TAG_OUT_WIDTH'(i);
      end
   end

   assign full         = &busy;
   assign alloc_needed = !((WRITE_NO_RSP != 0) && req_rw);
   assign grant        = !alloc_needed || !full;
   assign req_ready    = mem_ready && grant;
   assign mem_valid    = req_valid && grant;
   assign mem_tag      = alloc_needed ? free_idx : '0;
   assign alloc_fire   = req_valid && mem_ready && alloc_needed && !full;

   // A response naming a free entry is swallowed here so it cannot wedge the memory side.
   assign rsp_hit    = busy[rsp_idx];
   assign core_valid = rsp_valid && rsp_hit;
   assign rsp_ready  = rsp_hit ? core_ready : 1'b1;
   assign core_tag   = tag_mem[rsp_idx];
   assign free_fire  = core_valid && core_ready;

   assign alloc_mask = NUM_ENTRIES'(alloc_fire) << free_idx;
   assign free_mask  = NUM_ENTRIES'(free_fire) << rsp_idx;

   // Occupancy state: busy bits, live-entry count and sticky tag error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= '0;
         pending <= '0;
         tag_err <= 1'b0;
      end else begin
         busy <= (busy | alloc_mask) & ~free_mask;
         case ({alloc_fire, free_fire})
            2'b10:   pending <= pending + PEND_WIDTH'(1);
            2'b01:   pending <= pending - PEND_WIDTH'(1);
            default: pending <= pending;
         endcase
         if (rsp_valid && !rsp_hit) tag_err <= 1'b1;
      end
   end

   // Tag storage: written at the fire edge into the index granted that cycle; contents need no reset.
   always_ff @(posedge clk) begin
      if (alloc_fire) tag_mem[free_idx] <= req_tag;
   end

endmodule

// File: rtl/vx_mem_tag_remap.sv
// Memory-port tag compressor: wide core tags become narrow per-channel table indices and back.
// Latency: 0 cycles on request and response paths.
// Backpressure: per channel; allocating requests stall on a full table, writes without response pass.
module vx_mem_tag_remap
   import vx_mem_tag_remap_pkg::*;
#(
   parameter  int NUM_CHANNELS  = 1,
   parameter  int NUM_ENTRIES   = 8,
   parameter  int TAG_IN_WIDTH  = 16,
   parameter  int REQ_DATAW     = 64,
   parameter  int RSP_DATAW     = 64,
   parameter  int WRITE_NO_RSP  = 1,
   localparam int TAG_OUT_WIDTH = remap_tag_width(NUM_ENTRIES),
   localparam int PEND_WIDTH    = TAG_OUT_WIDTH + 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_CHANNELS-1:0]               core_req_valid,
   input  logic [NUM_CHANNELS-1:0]               core_req_rw,
   input  logic [NUM_CHANNELS*REQ_DATAW-1:0]     core_req_data,
   input  logic [NUM_CHANNELS*TAG_IN_WIDTH-1:0]  core_req_tag,
   output logic [NUM_CHANNELS-1:0]               core_req_ready,
   output logic [NUM_CHANNELS-1:0]               mem_req_valid,
   output logic [NUM_CHANNELS-1:0]               mem_req_rw,
   output logic [NUM_CHANNELS*REQ_DATAW-1:0]     mem_req_data,
   output logic [NUM_CHANNELS*TAG_OUT_WIDTH-1:0] mem_req_tag,
   input  logic [NUM_CHANNELS-1:0]               mem_req_ready,
   input  logic [NUM_CHANNELS-1:0]               mem_rsp_valid,
   input  logic [NUM_CHANNELS*RSP_DATAW-1:0]     mem_rsp_data,
   input  logic [NUM_CHANNELS*TAG_OUT_WIDTH-1:0] mem_rsp_tag,
   output logic [NUM_CHANNELS-1:0]               mem_rsp_ready,
   output logic [NUM_CHANNELS-1:0]               core_rsp_valid,
   output logic [NUM_CHANNELS*RSP_DATAW-1:0]     core_rsp_data,
   output logic [NUM_CHANNELS*TAG_IN_WIDTH-1:0]  core_rsp_tag,
   input  logic [NUM_CHANNELS-1:0]               core_rsp_ready,
   output logic [NUM_CHANNELS*PEND_WIDTH-1:0]    pending,
   output logic [NUM_CHANNELS-1:0]               tag_err
);

   // Payloads and the rw bit are untouched; only tags are rewritten.
   assign mem_req_rw    = core_req_rw;
   assign mem_req_data  = core_req_data;
   assign core_rsp_data = mem_rsp_data;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      vx_tag_table #(
         .NUM_ENTRIES  (NUM_ENTRIES),
         .TAG_IN_WIDTH (TAG_IN_WIDTH),
         .WRITE_NO_RSP (WRITE_NO_RSP)
      ) u_table (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (core_req_valid[c]),
         .req_rw     (core_req_rw[c]),
         .req_tag    (core_req_tag[c*TAG_IN_WIDTH +: TAG_IN_WIDTH]),
         .req_ready  (core_req_ready[c]),
         .mem_valid  (mem_req_valid[c]),
         .mem_tag    (mem_req_tag[c*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]),
         .mem_ready  (mem_req_ready[c]),
         .rsp_valid  (mem_rsp_valid[c]),
         .rsp_idx    (mem_rsp_tag[c*TAG_OUT_WIDTH +: TAG_OUT_WIDTH]),
         .rsp_ready  (mem_rsp_ready[c]),
         .core_valid (core_rsp_valid[c]),
         .core_tag   (core_rsp_tag[c*TAG_IN_WIDTH +: TAG_IN_WIDTH]),
         .core_ready (core_rsp_ready[c]),
         .pending    (pending[c*PEND_WIDTH +: PEND_WIDTH]),
         .tag_err    (tag_err[c])
      );
   end

endmodule
